hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage core. It drives the stall, bubble and flush controls of the PC, the IF/ID register and the ID/EX register, and a global hold for the EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory accesses. It sits beside the ID stage and consumes the ID/EX control fields and register addresses.

---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush sequencing for the 5-stage pipeline.
// Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory
// accesses (with a timeout that sets a sticky error flag).
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_RTaddr_i,
    input  logic [4:0]       IF_ID_RSaddr_i,
    input  logic [4:0]       IF_ID_RTaddr_i,
    input  logic             Branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Bubble_o,
    output logic             Pipe_Hold_o,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic             mem_err_o
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       err_d;
    logic       lu;
    logic       ms;

    // Load-use: the load in EX writes a register the instruction in ID reads.
    assign lu = ID_EX_MemRead_i && (ID_EX_RTaddr_i != 5'd0) &&
                ((ID_EX_RTaddr_i == IF_ID_RSaddr_i) || (ID_EX_RTaddr_i == IF_ID_RTaddr_i));

    // Next-state logic and prioritised hazard outputs (Mealy in RUN).
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        err_d          = mem_err_o;
        ms             = 1'b0;
        PCWrite_o      = 1'b1;
        IF_ID_Write_o  = 1'b1;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Bubble_o = 1'b0;
        Pipe_Hold_o    = 1'b0;

        case (state_q)
            RUN: begin
                ms = mem_req_i && !mem_ack_i;
                if (ms) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = 8'd1;
                end
            end
            MEM_WAIT: begin
                // mem_req_i is deliberately ignored while an access is outstanding.
                ms = !mem_ack_i && (wcnt_q < TIMEOUT);
                if (mem_ack_i) begin
                    state_d = RUN;
                    wcnt_d  = 8'd0;
                end else if (wcnt_q == TIMEOUT) begin
                    state_d = RUN;
                    wcnt_d  = 8'd0;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = 8'd0;
            end
        endcase

        if (rst_i) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            IF_ID_Flush_o  = 1'b1;
            ID_EX_Bubble_o = 1'b1;
            Pipe_Hold_o    = 1'b0;
        end else if (ms) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            Pipe_Hold_o    = 1'b1;
        end else if (lu) begin
            // A coincident taken branch stays in ID and is re-evaluated next cycle.
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
        end else if (Branch_taken_i) begin
            IF_ID_Flush_o  = 1'b1;
        end
    end

    // State, wait counter and sticky error register; reset abandons any access.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q   <= RUN;
            wcnt_q    <= 8'd0;
            mem_err_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_o <= err_d;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating statistics: stall cycles and flush cycles outside reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!PCWrite_o && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (IF_ID_Flush_o && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
`endif

endmodule
